// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency word memory slave answering the core's memory interface
module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_address,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [29:0]   idx_q;
  logic          rd_q, wr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic          accept;

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          unused_addr;
  assign unused_addr = ^mem_address[1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          accept  = 1'b1;
          cnt_d   = CW'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With LATENCY==1 the access happens on the accepting edge, so take the live inputs.
  logic [29:0] t_idx;
  logic        t_rd, t_wr;
  logic [3:0]  t_be;
  logic [31:0] t_wdata;
  logic        enter_resp, in_range, conflict, do_write;

  always_comb begin
    if (state_q == IDLE) begin
      t_idx   = mem_address[31:2];
      t_rd    = mem_read;
      t_wr    = mem_write;
      t_be    = mem_byte_enable;
      t_wdata = mem_wdata;
    end else begin
      t_idx   = idx_q;
      t_rd    = rd_q;
      t_wr    = wr_q;
      t_be    = be_q;
      t_wdata = wdata_q;
    end
  end

  assign enter_resp = (state_d == RESP) && (state_q != RESP);
  assign in_range   = t_idx < 30'(DEPTH_WORDS);
  assign conflict   = t_rd && t_wr;
  assign do_write   = rst && enter_resp && t_wr && !t_rd && in_range;

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (t_be[b]) mem_q[t_idx[AW-1:0]][8*b +: 8] <= t_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q   <= mem_address[31:2];
        rd_q    <= mem_read;
        wr_q    <= mem_write;
        be_q    <= mem_byte_enable;
        wdata_q <= mem_wdata;
      end
      if (enter_resp) begin
        if (conflict || !in_range) err_q <= 1'b1;
        // Write-only responses leave the previous read data in place.
        if (conflict)  rdata_q <= '0;
        else if (t_rd) rdata_q <= in_range ? mem_q[t_idx[AW-1:0]] : 32'h0;
      end
    end
  end

  assign mem_resp  = (state_q == RESP);
  assign mem_rdata = rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder against a word-array model
module tb_mem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] mem_address = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [3:0]  mem_byte_enable = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        err;

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .err(err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [31:0] model [int];
  logic [31:0] exp_rdata = '0;
  logic        exp_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_err = 1'b0;
    exp_rdata = '0;
  endtask

  // Called at a negedge in an idle cycle; returns at the negedge of the following idle cycle.
  task automatic txn(input string tag, input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [3:0] be, input logic [31:0] wdata);
    int k;
    bit got;
    int idx;
    bit oor;
    logic [31:0] w;
    mem_read = rd;
    mem_write = wr;
    mem_address = addr;
    mem_byte_enable = be;
    mem_wdata = wdata;
    @(posedge clk);
    idx = int'(addr[31:2]);
    oor = idx >= DEPTH;
    if (rd && wr) begin
      exp_err = 1'b1;
      exp_rdata = '0;
    end else begin
      if (oor) exp_err = 1'b1;
      if (wr && !oor) begin
        w = model.exists(idx) ? model[idx] : 32'h0;
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
        model[idx] = w;
      end
      if (rd) exp_rdata = oor ? 32'h0 : model[idx];
    end
    k = 0;
    got = 0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        mem_read = 1'b0;
        mem_write = 1'b0;
        mem_address = $urandom;
        mem_wdata = $urandom;
      end
      if (mem_resp) got = 1;
    end
    check({tag, " latency"}, 32'(k), 32'(LAT));
    check({tag, " rdata"}, mem_rdata, exp_rdata);
    @(negedge clk);
    check({tag, " resp_width"}, {31'b0, mem_resp}, 32'h0);
    check({tag, " err"}, {31'b0, err}, {31'b0, exp_err});
  endtask

  initial begin
    int resp_seen;
    logic [31:0] addr;
    logic [3:0] be;
    int kind;

    // reset
    @(posedge clk);
    @(negedge clk);
    check("reset resp", {31'b0, mem_resp}, 32'h0);
    check("reset rdata", mem_rdata, 32'h0);
    check("reset err", {31'b0, err}, 32'h0);
    rst = 1'b1;

    // preload a 16-word window
    for (int i = 0; i < 16; i++) txn("preload", 0, 1, 32'(i * 4), 4'hF, $urandom);

    // write then read
    txn("wr_10", 0, 1, 32'h10, 4'hF, 32'hDEADBEEF);
    txn("rd_10", 1, 0, 32'h10, 4'hF, 32'h0);
    check("rd_10 const", mem_rdata, 32'hDEADBEEF);
    check("rd_10 err", {31'b0, err}, 32'h0);

    // partial write
    txn("pre_20", 0, 1, 32'h20, 4'hF, 32'h11223344);
    txn("pw_20", 0, 1, 32'h20, 4'b0101, 32'hAABBCCDD);
    txn("rd_20", 1, 0, 32'h20, 4'h0, 32'h0);
    check("rd_20 const", mem_rdata, 32'h11BB33DD);

    // back-to-back, misaligned, empty byte enable
    txn("b2b_10", 1, 0, 32'h10, 4'h0, 32'h0);
    txn("b2b_14", 1, 0, 32'h14, 4'h0, 32'h0);
    txn("mis_13", 1, 0, 32'h13, 4'h0, 32'h0);
    txn("be0_14", 0, 1, 32'h14, 4'h0, 32'hFFFFFFFF);
    txn("rd_14", 1, 0, 32'h14, 4'h0, 32'h0);

    // out of range
    txn("oor_wr", 0, 1, 32'h1000, 4'hF, 32'hCAFEF00D);
    txn("oor_rd", 1, 0, 32'h1000, 4'hF, 32'h0);
    check("oor err", {31'b0, err}, 32'h1);
    txn("in_rd_after_oor", 1, 0, 32'h0, 4'h0, 32'h0);
    check("oor err sticky", {31'b0, err}, 32'h1);
    do_reset();
    check("err cleared", {31'b0, err}, 32'h0);

    // read/write conflict
    txn("conflict", 1, 1, 32'h10, 4'hF, 32'h55555555);
    check("conflict err", {31'b0, err}, 32'h1);
    txn("rd_10_after_conflict", 1, 0, 32'h10, 4'h0, 32'h0);
    check("conflict unchanged", mem_rdata, 32'hDEADBEEF);
    do_reset();

    // reset while busy
    mem_write = 1'b1;
    mem_address = 32'h30;
    mem_byte_enable = 4'hF;
    mem_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    mem_write = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_err = 1'b0;
    exp_rdata = '0;
    resp_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (mem_resp) resp_seen++;
      @(negedge clk);
    end
    check("abort no resp", 32'(resp_seen), 32'h0);
    txn("rd_30_after_abort", 1, 0, 32'h30, 4'h0, 32'h0);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 9));
      addr = {26'($urandom_range(0, 15)), 2'($urandom)} << 0;
      addr = {24'h0, addr[5:0]};
      if (kind == 9) addr = 32'h1000 + ($urandom_range(0, 255) * 4);
      be = 4'($urandom);
      if (kind < 4)       txn("rnd_rd", 1, 0, addr, be, $urandom);
      else if (kind < 8)  txn("rnd_wr", 0, 1, addr, be, $urandom);
      else if (kind == 8) txn("rnd_rw", 1, 1, addr, be, $urandom);
      else                txn("rnd_oor", $urandom_range(0, 1) == 1, 1, addr, be, $urandom);
      if (i == 30) do_reset();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed %0d checks expected completion", total);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Single-port, word-organised memory slave that answers the CPU datapath's memory interface (mem_read/mem_write/mem_byte_enable/mem_address/mem_wdata → mem_rdata/mem_resp).
- Responds after a fixed, parameterised latency.
- Stands in for the "magic memory" on the responder side of the multicycle RV32I core, so the core's control FSM can be exercised with realistic wait states in synthesisable benches.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words stored; legal word index is 0..DEPTH_WORDS-1.
- LATENCY, 3, cycles from request acceptance to mem_resp; legal range >= 1.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk
- mem_address  input  32  byte address; word index = mem_address[31:2], bits [1:0] ignored
- mem_read  input  1  read request
- mem_write  input  1  write request
- mem_byte_enable  input  4  per-byte write enable; bit i covers wdata[8i+7:8i]
- mem_wdata  input  32  write data
- mem_rdata  output  32  read data, valid only in the mem_resp cycle
- mem_resp  output  1  one-cycle completion pulse
- err  output  1  sticky error flag: out-of-range access or simultaneous read+write

Behaviour:
- Reset (rst==0 at an edge):
  - state=IDLE; mem_resp=0; mem_rdata=0; err=0; latency counter=0.
  - Storage contents are not cleared.
  - Reset mid-operation aborts the transaction; a pending write is not committed.
- States: IDLE, BUSY, RESP.
- IDLE:
  - At an edge with mem_read|mem_write high, latch address, read, write, byte_enable and wdata.
  - Load counter with LATENCY-1, then go to BUSY; if LATENCY==1, go directly to RESP.
- BUSY:
  - Counter decrements each edge.
  - When counter==1 at an edge, go to RESP.
  - Inputs are ignored; request changes or deassertion do not affect the latched transaction.
- RESP:
  - mem_resp=1 for exactly one cycle.
  - Next edge returns to IDLE.
  - A request present in IDLE's first cycle is accepted normally (back-to-back allowed; no dead cycle beyond the IDLE sample).
- Latency:
  - Request accepted at edge E0.
  - mem_resp is high in the cycle following edge E0+LATENCY-1, i.e. LATENCY cycles after the acceptance cycle.
  - Example: LATENCY=3 gives request cycle C0 and resp in C3.
- Read:
  - mem_rdata is loaded on the edge entering RESP from storage[index].
  - It reflects all writes committed before that edge.
  - mem_rdata holds its value outside RESP; it is not zeroed.
- Write:
  - Committed on the edge entering RESP.
  - Only bytes with byte_enable=1 are updated.
  - byte_enable=0000 is a legal no-op that still responds.
- Out of range (index >= DEPTH_WORDS):
  - Write is dropped; read returns 0x00000000.
  - err set to 1 and held until reset.
  - mem_resp is still issued at normal latency.
- Simultaneous mem_read and mem_write at acceptance:
  - No storage access; mem_rdata=0; err set.
  - mem_resp still issued at normal latency.
- Address alignment: misaligned byte addresses are treated as the containing word; no error.

Test Plan:
- Reset, then LATENCY=3: write 0xDEADBEEF to 0x0000_0010 with be=1111, then read 0x10 → mem_resp exactly 3 cycles after each request cycle, one cycle wide; read returns 0xDEADBEEF; err=0.
- Partial write: preload 0x11223344 at 0x20, write 0xAABBCCDD with be=0101 → read 0x20 returns 0x11BB33DD.
- Back-to-back: read 0x10, then hold mem_read for 0x14 in the cycle right after resp → second resp arrives exactly LATENCY cycles later; data per address.
- Out of range with DEPTH_WORDS=1024: write to 0x0000_1000, then read it → both get mem_resp; read returns 0; err=1 and stays 1 until rst=0 for one edge, then err=0.
- Conflict: read and write high together at 0x10 → resp after LATENCY; storage at 0x10 unchanged; err=1.
- Reset mid-BUSY: start write 0x12345678 to 0x30, assert rst=0 one cycle later → no mem_resp; subsequent read of 0x30 returns its old value.
